// File: rtl/sram_port_arb.sv
// Round-robin arbiter sharing one single-port SRAM among NREQ requesters.
// Owners may lock the port for multi-beat sequences; a hold timeout reclaims it.
module sram_port_arb #(
  parameter int NREQ     = 2,
  parameter int AW       = 15,
  parameter int DW       = 32,
  parameter int HOLD_TMO = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_last_i,
  input  logic [NREQ-1:0]      req_write_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  input  logic [NREQ*DW/8-1:0] req_wstrb_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [DW-1:0]        rsp_rdata_o,
  output logic                 mem_cs_o,
  output logic [DW/8-1:0]      mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic [DW-1:0]        mem_rdata_i,
  output logic                 arb_tmo_o
);

  localparam int SW = DW / 8;
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_TMO);

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0] rsp_pend_q, rsp_pend_d;
  logic            arb_tmo_q, arb_tmo_d;
  logic [DW-1:0]   rdata_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;

  logic [PW-1:0]   cand_s, pick_idx_s, grant_idx_s;
  logic            hit_s, pick_found_s, grant_elig_s, accept_s;
  logic [NREQ-1:0] ready_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_wdata_s;
  logic [SW-1:0]   sel_wstrb_s;
  logic            sel_last_s, sel_write_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(NREQ - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Circular search for the first valid requester starting at rr_ptr.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = rr_ptr_q;
    cand_s       = rr_ptr_q;
    hit_s        = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      hit_s        = req_valid_i[cand_s] & ~pick_found_s;
      pick_idx_s   = hit_s ? cand_s : pick_idx_s;
      pick_found_s = pick_found_s | hit_s;
      cand_s       = wrap_inc(cand_s);
    end
  end

  always_comb begin
    ready_s = {NREQ{1'b0}};
    if (state_q == ST_LOCKED) begin
      grant_idx_s  = owner_q;
      grant_elig_s = req_valid_i[owner_q];
    end else begin
      grant_idx_s  = pick_idx_s;
      grant_elig_s = pick_found_s;
    end
    if (rstn && grant_elig_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  assign accept_s    = |ready_s;
  assign sel_addr_s  = req_addr_i[int'(grant_idx_s)*AW +: AW];
  assign sel_wdata_s = req_wdata_i[int'(grant_idx_s)*DW +: DW];
  assign sel_wstrb_s = req_wstrb_i[int'(grant_idx_s)*SW +: SW];
  assign sel_last_s  = req_last_i[grant_idx_s];
  assign sel_write_s = req_write_i[grant_idx_s];

  // The SRAM address/data bus keeps its last driven value between accesses.
  assign req_ready_o = ready_s;
  assign mem_cs_o    = accept_s;
  assign mem_we_o    = (accept_s && sel_write_s) ? sel_wstrb_s : {SW{1'b0}};
  assign mem_addr_o  = accept_s ? sel_addr_s : mem_addr_q;
  assign mem_wdata_o = accept_s ? sel_wdata_s : mem_wdata_q;
  assign rsp_valid_o = rstn ? rsp_pend_q : {NREQ{1'b0}};
  assign rsp_rdata_o = (|rsp_valid_o) ? mem_rdata_i : rdata_q;
  assign arb_tmo_o   = arb_tmo_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    arb_tmo_d  = 1'b0;
    rsp_pend_d = {NREQ{1'b0}};
    if (accept_s) begin
      hold_cnt_d = {CW{1'b0}};
      if (sel_last_s) begin
        state_d  = ST_UNLOCKED;
        rr_ptr_d = wrap_inc(grant_idx_s);
      end else begin
        state_d = ST_LOCKED;
        owner_d = grant_idx_s;
      end
      if (!sel_write_s) begin
        rsp_pend_d[grant_idx_s] = 1'b1;
      end else begin
        rsp_pend_d = {NREQ{1'b0}};
      end
    end else if ((state_q == ST_LOCKED) && !req_valid_i[owner_q]) begin
      // Stalled owner: count idle cycles and force a release at the limit.
      if (hold_cnt_q == CW'(HOLD_TMO - 1)) begin
        state_d    = ST_UNLOCKED;
        rr_ptr_d   = wrap_inc(owner_q);
        hold_cnt_d = {CW{1'b0}};
        arb_tmo_d  = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + CW'(1);
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_UNLOCKED;
      owner_q     <= {PW{1'b0}};
      rr_ptr_q    <= {PW{1'b0}};
      hold_cnt_q  <= {CW{1'b0}};
      rsp_pend_q  <= {NREQ{1'b0}};
      arb_tmo_q   <= 1'b0;
      rdata_q     <= {DW{1'b0}};
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      rsp_pend_q  <= rsp_pend_d;
      arb_tmo_q   <= arb_tmo_d;
      rdata_q     <= rsp_rdata_o;
      mem_addr_q  <= mem_addr_o;
      mem_wdata_q <= mem_wdata_o;
    end
  end

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the arbitration rules and the SRAM.
module tb_sram_port_arb;

  localparam int NREQ     = 2;
  localparam int AW       = 15;
  localparam int DW       = 32;
  localparam int SW       = DW / 8;
  localparam int PW       = $clog2(NREQ);
  localparam int HOLD_TMO = 16;
  localparam int DEPTH    = 1 << AW;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid, req_ready, req_last, req_write, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*SW-1:0]   req_wstrb;
  logic [DW-1:0]        rsp_rdata, mem_wdata, sram_rdata;
  logic                 mem_cs, arb_tmo;
  logic [SW-1:0]        mem_we;
  logic [AW-1:0]        mem_addr;

  sram_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .HOLD_TMO(HOLD_TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_last_i(req_last),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(sram_rdata), .arb_tmo_o(arb_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 32) return 32'hDEADDEAD;
    else return 32'hC0DE0000 | DW'(i);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM macro: registered read data, byte-enabled writes.
  logic [DW-1:0] sram [DEPTH];
  bit sram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      sram_init_done <= 1'b1;
    end else if (mem_cs) begin
      sram_rdata <= sram[mem_addr];
      sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_we);
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_locked = 1'b0, m_pend = 1'b0, m_tmo = 1'b0;
  bit            m_addr_known = 1'b0, m_rdata_known = 1'b0;
  int            m_owner = 0, m_rr = 0, m_idle = 0, m_pidx = 0;
  logic [AW-1:0] m_paddr = '0, m_last_addr = '0;
  logic [DW-1:0] m_last_rdata = '0, m_last_wdata = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [NREQ-1:0] obs_ready, obs_rspv;
  logic            obs_cs, obs_tmo;
  logic [SW-1:0]   obs_we;
  logic [AW-1:0]   obs_addr;
  logic [DW-1:0]   obs_rdata;
  logic [1:0]      cont_exp [4];
  logic            r_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic last, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i] = v;
    req_last[i]  = last;
    req_write[i] = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock: inputs set at negedge, outputs checked 1 unit later, model steps at posedge.
  task automatic run_cycle();
    logic [NREQ-1:0] e_ready, e_rspv;
    logic [SW-1:0]   e_we, g_strb;
    logic [DW-1:0]   e_rdata, g_wdata;
    logic [AW-1:0]   g_addr;
    logic            elig;
    int              g;
    #1;
    elig = 1'b0;
    g    = 0;
    if (rstn) begin
      if (m_locked) begin
        g    = m_owner;
        elig = req_valid[PW'(m_owner)];
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (!elig && req_valid[PW'((m_rr + k) % NREQ)]) begin
            elig = 1'b1;
            g    = (m_rr + k) % NREQ;
          end
        end
      end
    end
    g_addr  = req_addr[g*AW +: AW];
    g_wdata = req_wdata[g*DW +: DW];
    g_strb  = req_wstrb[g*SW +: SW];
    e_ready = '0;
    if (elig) e_ready[PW'(g)] = 1'b1;
    e_we   = (elig && req_write[PW'(g)]) ? g_strb : '0;
    e_rspv = '0;
    if (rstn && m_pend) e_rspv[PW'(m_pidx)] = 1'b1;
    e_rdata = (rstn && m_pend) ? ref_mem[m_paddr] : m_last_rdata;

    obs_ready = req_ready; obs_rspv = rsp_valid; obs_cs = mem_cs; obs_tmo = arb_tmo;
    obs_we = mem_we; obs_addr = mem_addr; obs_rdata = rsp_rdata;

    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("mem_cs", 64'(mem_cs), 64'(elig));
    check("mem_we", 64'(mem_we), 64'(e_we));
    if (elig) begin
      check("mem_addr", 64'(mem_addr), 64'(g_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(g_wdata));
    end else if (rstn && m_addr_known) begin
      check("mem_addr_hold", 64'(mem_addr), 64'(m_last_addr));
      check("mem_wdata_hold", 64'(mem_wdata), 64'(m_last_wdata));
    end
    check("rsp_valid", 64'(rsp_valid), 64'(e_rspv));
    if (m_rdata_known) check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
    if (rstn) check("arb_tmo", 64'(arb_tmo), 64'(m_tmo));

    @(posedge clk);
    if (!rstn) begin
      m_locked = 1'b0; m_owner = 0; m_rr = 0; m_idle = 0; m_pend = 1'b0; m_tmo = 1'b0;
      m_last_rdata = '0; m_rdata_known = 1'b1; m_addr_known = 1'b0;
    end else begin
      m_last_rdata = e_rdata;
      m_tmo  = 1'b0;
      m_pend = 1'b0;
      if (elig) begin
        m_addr_known = 1'b1;
        m_last_addr  = g_addr;
        m_last_wdata = g_wdata;
        m_idle       = 0;
        if (req_write[PW'(g)]) ref_mem[g_addr] = merge(ref_mem[g_addr], g_wdata, g_strb);
        else begin
          m_pend = 1'b1; m_pidx = g; m_paddr = g_addr;
        end
        if (req_last[PW'(g)]) begin
          m_locked = 1'b0; m_rr = (g + 1) % NREQ;
        end else begin
          m_locked = 1'b1; m_owner = g;
        end
      end else if (m_locked) begin
        m_idle++;
        if (m_idle == HOLD_TMO) begin
          m_locked = 1'b0; m_rr = (m_owner + 1) % NREQ; m_tmo = 1'b1; m_idle = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    rstn = 1'b0;
    clear_reqs();
    set_req(0, 1'b1, 1'b1, 1'b0, 15'h0001, 32'h0, 4'h0);
    @(negedge clk);
    run_cycle();
    run_cycle();
    check("rst_ready", 64'(obs_ready), 64'(2'b00));
    check("rst_cs", 64'(obs_cs), 64'(1'b0));
    rstn = 1'b1;

    // Contention: two single-beat writers alternate
    set_req(0, 1'b1, 1'b1, 1'b1, 15'h0040, 32'h11111111, 4'hF);
    set_req(1, 1'b1, 1'b1, 1'b1, 15'h0041, 32'h22222222, 4'hF);
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      check("cont_grant", 64'(obs_ready), 64'(cont_exp[c]));
    end
    clear_reqs();

    // Single read of word 4
    set_req(0, 1'b1, 1'b1, 1'b0, 15'h0004, 32'h0, 4'h0);
    run_cycle();
    check("rd_ready", 64'(obs_ready), 64'(2'b01));
    check("rd_cs", 64'(obs_cs), 64'(1'b1));
    check("rd_we", 64'(obs_we), 64'(4'b0000));
    check("rd_addr", 64'(obs_addr), 64'(15'h0004));
    clear_reqs();
    run_cycle();
    check("rd_rspv", 64'(obs_rspv), 64'(2'b01));
    check("rd_data", 64'(obs_rdata), 64'(32'hC0DE0004));

    // Locked burst from req1 while req0 waits
    set_req(0, 1'b1, 1'b1, 1'b0, 15'h0050, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, (k == 3), 1'b0, AW'(16 + k), 32'h0, 4'h0);
      run_cycle();
      check("burst_ready", 64'(obs_ready), 64'(2'b10));
      if (k == 1) check("burst_data", 64'(obs_rdata), 64'(32'hC0DE0010));
    end
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    run_cycle();
    check("burst_after", 64'(obs_ready), 64'(2'b01));
    clear_reqs();
    run_cycle();

    // Partial byte write then readback
    set_req(0, 1'b1, 1'b1, 1'b1, 15'h0020, 32'hA5A5A5A5, 4'h3);
    run_cycle();
    check("bw_we", 64'(obs_we), 64'(4'b0011));
    set_req(0, 1'b1, 1'b1, 1'b0, 15'h0020, 32'h0, 4'h0);
    run_cycle();
    clear_reqs();
    run_cycle();
    check("bw_readback", 64'(obs_rdata), 64'(32'hDEADA5A5));

    // Hold timeout
    set_req(0, 1'b1, 1'b0, 1'b0, 15'h0005, 32'h0, 4'h0);
    run_cycle();
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 1'b1, 1'b0, 15'h0006, 32'h0, 4'h0);
    for (int k = 0; k < HOLD_TMO; k++) begin
      run_cycle();
      check("tmo_hold_ready", 64'(obs_ready), 64'(2'b00));
      check("tmo_early", 64'(obs_tmo), 64'(1'b0));
    end
    run_cycle();
    check("tmo_pulse", 64'(obs_tmo), 64'(1'b1));
    check("tmo_regrant", 64'(obs_ready), 64'(2'b10));
    clear_reqs();
    run_cycle();
    check("tmo_once", 64'(obs_tmo), 64'(1'b0));

    // Reset in the middle of a locked sequence
    set_req(0, 1'b1, 1'b0, 1'b0, 15'h0007, 32'h0, 4'h0);
    run_cycle();
    rstn = 1'b0;
    set_req(1, 1'b1, 1'b1, 1'b0, 15'h0008, 32'h0, 4'h0);
    run_cycle();
    check("rstmid_rspv", 64'(obs_rspv), 64'(2'b00));
    check("rstmid_ready", 64'(obs_ready), 64'(2'b00));
    rstn = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    run_cycle();
    check("rstmid_unlock", 64'(obs_ready), 64'(2'b10));
    clear_reqs();
    run_cycle();

    // Random traffic; req0 goes quiet periodically to exercise the timeout
    for (int c = 0; c < 400; c++) begin
      rstn = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < NREQ; i++) begin
        r_v = ($urandom_range(0, 9) < 6);
        if (i == 0 && (c % 80) < 24) r_v = 1'b0;
        set_req(i, r_v, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                AW'(64 + $urandom_range(0, 63)), DW'($urandom), SW'($urandom_range(0, 15)));
      end
      run_cycle();
    end
    rstn = 1'b1;
    clear_reqs();
    run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
